// File: rtl/pwm_clock_gen_multi.sv
// Multi-channel phase-aligned clock/enable generator with per-channel duty and glitch-free shadow reload.
// Latency: 1 clk from enable (with period!=0) to first registered clk_out/period_start.
// Backpressure: none; period/duty inputs are sampled only at period boundaries or on start from IDLE.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   enable             level-sensitive run request
//   period             period length in clk cycles (0 = disabled)
//   duty               packed per-channel high counts, channel i = duty[i*WIDTH +: WIDTH]
//   clk_out            registered channel waveforms
//   period_start       high during count 0 of every period
//   busy               high while running or draining
module pwm_clock_gen_multi #(
  parameter int WIDTH     = 8,
  parameter int NCH       = 4,
  parameter int STOP_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [WIDTH-1:0]     period,
  input  logic [NCH*WIDTH-1:0] duty,
  output logic [NCH-1:0]       clk_out,
  output logic                 period_start,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     period_sh_q, period_sh_d;
  logic [NCH*WIDTH-1:0] duty_sh_q, duty_sh_d;
  logic [NCH-1:0]       clk_out_q, clk_out_d;
  logic                 period_start_q, period_start_d;

  logic                 wrap;
  logic                 start_ok;

  // period_sh is never 0 outside IDLE, so the subtraction cannot underflow where it matters.
  assign wrap     = (cnt_q == period_sh_q - 1'b1);
  assign start_ok = enable && (period != '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      period_sh_q    <= '0;
      duty_sh_q      <= '0;
      clk_out_q      <= '0;
      period_start_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      period_sh_q    <= period_sh_d;
      duty_sh_q      <= duty_sh_d;
      clk_out_q      <= clk_out_d;
      period_start_q <= period_start_d;
    end
  end

  // Next-state: counter, shadows and FSM
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_sh_d = period_sh_q;
    duty_sh_d   = duty_sh_q;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d     = RUN;
          cnt_d       = '0;
          period_sh_d = period;
          duty_sh_d   = duty;
        end
      end
      RUN: begin
        if (wrap) begin
          cnt_d = '0;
          if (start_ok) begin
            period_sh_d = period;
            duty_sh_d   = duty;
          end else begin
            state_d = IDLE;
          end
        end else if (!enable) begin
          if (STOP_MODE == 0) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = DRAIN;
            cnt_d   = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (wrap) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are computed from the next count and next shadow duty so that the
  // registered waveform matches the count during the same cycle.
  always_comb begin
    clk_out_d      = '0;
    period_start_d = 1'b0;
    if (state_d != IDLE) begin
      period_start_d = (cnt_d == '0);
      for (int i = 0; i < NCH; i++) begin
        clk_out_d[i] = (cnt_d < duty_sh_d[i*WIDTH +: WIDTH]);
      end
    end
  end

  assign clk_out      = clk_out_q;
  assign period_start = period_start_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_pwm_clock_gen_multi.sv
// Bench for pwm_clock_gen_multi: one instance per stop mode driven by shared inputs.
// Latency: expected outputs compared at the negedge following each rising edge.
// Backpressure: not applicable.
module tb_pwm_clock_gen_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [7:0]  period;
  logic [31:0] duty;
  logic [3:0]  co0, co1;
  logic        ps0, ps1, b0, b1;

  always #5 clk = ~clk;

  pwm_clock_gen_multi #(.WIDTH(8), .NCH(4), .STOP_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .period(period), .duty(duty),
    .clk_out(co0), .period_start(ps0), .busy(b0)
  );

  pwm_clock_gen_multi #(.WIDTH(8), .NCH(4), .STOP_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .period(period), .duty(duty),
    .clk_out(co1), .period_start(ps1), .busy(b1)
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: each period's full waveform is scheduled up front when it
  // starts; the model then just walks the schedule, abandoning it on a stop.
  // Index m doubles as the stop mode of the matching instance.
  logic [4:0] sched [2][256];   // {period_start, clk_out[3:0]}
  int         pos   [2];
  int         len   [2];
  int         mode  [2];        // 0 idle, 1 run, 2 drain
  logic [4:0] cur   [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mode[m] = 0; pos[m] = 0; len[m] = 0; cur[m] = '0;
    end
  endtask

  task automatic load(input int m);
    logic [7:0] d;
    len[m] = int'(period);
    pos[m] = 0;
    for (int k = 0; k < len[m]; k++) begin
      sched[m][k][4] = (k == 0);
      for (int i = 0; i < 4; i++) begin
        d = duty[i*8 +: 8];
        sched[m][k][i] = (k < int'(d));
      end
    end
    mode[m] = 1;
    cur[m]  = sched[m][0];
  endtask

  task automatic go_idle(input int m);
    mode[m] = 0;
    cur[m]  = '0;
  endtask

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      if (mode[m] == 0) begin
        if (enable && period != 0) load(m);
        else go_idle(m);
      end else if (pos[m] == len[m] - 1) begin
        if (mode[m] == 1 && enable && period != 0) load(m);
        else go_idle(m);
      end else if (mode[m] == 1 && !enable && m == 0) begin
        go_idle(m);
      end else begin
        if (mode[m] == 1 && !enable) mode[m] = 2;
        pos[m]++;
        cur[m] = sched[m][pos[m]];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("m0_clk_out", co0, cur[0][3:0]);
    chk("m0_pstart",  ps0, cur[0][4]);
    chk("m0_busy",    b0,  mode[0] != 0);
    chk("m1_clk_out", co1, cur[1][3:0]);
    chk("m1_pstart",  ps1, cur[1][4]);
    chk("m1_busy",    b1,  mode[1] != 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    enable = 1'b0;
    while ((b0 || b1) && n < 300) begin
      step();
      n++;
    end
    chk("idle_wait", b0 | b1, 0);
  endtask

  typedef struct {
    logic        en;
    logic [7:0]  per;
    logic [31:0] dty;
    logic [3:0]  co;
    logic        ps;
    logic        bz;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [8:0] seq_c, seq_p;
    int nb;

    // {ch3,ch2,ch1,ch0} = {4,3,2,1}, period 4
    for (int r = 0; r < 8; r++) begin
      tbl[r].en = 1'b1; tbl[r].per = 8'd4; tbl[r].dty = {8'd4, 8'd3, 8'd2, 8'd1};
      tbl[r].bz = 1'b1;
      case (r % 4)
        0:       begin tbl[r].co = 4'b1111; tbl[r].ps = 1'b1; end
        1:       begin tbl[r].co = 4'b1110; tbl[r].ps = 1'b0; end
        2:       begin tbl[r].co = 4'b1100; tbl[r].ps = 1'b0; end
        default: begin tbl[r].co = 4'b1000; tbl[r].ps = 1'b0; end
      endcase
    end
    tbl[8]  = '{en: 1'b0, per: 8'd4, dty: {8'd4, 8'd3, 8'd2, 8'd1}, co: 4'b0000, ps: 1'b0, bz: 1'b0};
    tbl[9]  = '{en: 1'b1, per: 8'd2, dty: {8'd0, 8'd1, 8'd2, 8'd3}, co: 4'b0111, ps: 1'b1, bz: 1'b1};
    tbl[10] = '{en: 1'b1, per: 8'd2, dty: {8'd0, 8'd1, 8'd2, 8'd3}, co: 4'b0011, ps: 1'b0, bz: 1'b1};
    tbl[11] = '{en: 1'b1, per: 8'd2, dty: {8'd0, 8'd1, 8'd2, 8'd3}, co: 4'b0111, ps: 1'b1, bz: 1'b1};

    rst = 1'b1; enable = 1'b0; period = '0; duty = '0;
    model_reset();
    #12;
    chk("rst_clk_out", {co1, co0}, 0);
    chk("rst_pstart",  {ps1, ps0}, 0);
    chk("rst_busy",    {b1, b0},   0);
    @(negedge clk);
    rst = 1'b0;

    // Table: duty mix, stop at wrap, restart with period 2
    for (int r = 0; r < 12; r++) begin
      enable = tbl[r].en; period = tbl[r].per; duty = tbl[r].dty;
      step();
      chk($sformatf("tbl%0d_co0", r), co0, tbl[r].co);
      chk($sformatf("tbl%0d_co1", r), co1, tbl[r].co);
      chk($sformatf("tbl%0d_ps", r),  ps0, tbl[r].ps);
      chk($sformatf("tbl%0d_busy", r), {b1, b0}, {2{tbl[r].bz}});
    end
    wait_idle();

    // 0% and >=100% duty across wraps
    period = 8'd10; duty = {8'd0, 8'd0, 8'd200, 8'd0}; enable = 1'b1;
    for (int j = 0; j < 25; j++) begin
      step();
      chk("const_ch0", co0[0], 1'b0);
      chk("const_ch1", co0[1], 1'b1);
    end
    wait_idle();

    // Mid-period period/duty change takes effect only at the wrap
    period = 8'd4; duty = {8'd0, 8'd0, 8'd0, 8'd1}; enable = 1'b1;
    step(); step();
    period = 8'd6; duty = {8'd0, 8'd0, 8'd0, 8'd3};
    for (int j = 0; j < 9; j++) begin
      step();
      seq_c[j] = co0[0];
      seq_p[j] = ps0;
    end
    chk("reload_ch0_seq", seq_c, 9'b100011100);
    chk("reload_ps_seq",  seq_p, 9'b100000100);
    wait_idle();

    // Enable dropped at cnt==2 with period 8
    period = 8'd8; duty = {8'd8, 8'd4, 8'd2, 8'd0}; enable = 1'b1;
    step(); step(); step();
    enable = 1'b0;
    step();
    chk("stop0_busy", b0, 1'b0);
    chk("stop0_clk",  co0, 4'b0000);
    chk("stop1_busy", b1, 1'b1);
    nb = 1;
    for (int j = 0; j < 20; j++) begin
      step();
      if (b1) nb++;
    end
    chk("drain_cycles", nb, 5);
    wait_idle();

    // Asynchronous reset in mid-period, then restart
    period = 8'd8; duty = {8'd8, 8'd4, 8'd2, 8'd1}; enable = 1'b1;
    step(); step(); step();
    #2 rst = 1'b1;
    #1;
    chk("arst_clk_out", {co1, co0}, 0);
    chk("arst_pstart",  {ps1, ps0}, 0);
    chk("arst_busy",    {b1, b0},   0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post_rst_ps", {ps1, ps0}, 2'b11);
    wait_idle();

    // Period 1, then period 0 at a wrap
    period = 8'd1; duty = {8'd0, 8'd0, 8'd0, 8'd1}; enable = 1'b1;
    for (int j = 0; j < 6; j++) begin
      step();
      chk("p1_ch10", co0[1:0], 2'b01);
      chk("p1_ps",   ps0, 1'b1);
    end
    period = 8'd0;
    step();
    chk("p0_busy", {b1, b0}, 2'b00);

    // Randomized inputs against the model
    for (int j = 0; j < 600; j++) begin
      if ($urandom_range(0, 5) == 0) begin
        period = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 12));
        for (int i = 0; i < 4; i++) duty[i*8 +: 8] = 8'($urandom_range(0, 14));
      end
      enable = ($urandom_range(0, 11) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
